// File: rtl/ifu_fetch_buffer.sv
// ifu_fetch_buffer: DEPTH-entry circular instruction FIFO between fetch and decode.
// Holds {inst, addr} pairs and has valid/ready handshakes on both sides.
// A flush empties the buffer in one cycle. When the buffer is empty, the
// outputs show a NOP at address 0.
module ifu_fetch_buffer #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013,
    localparam int               PTR_W    = $clog2(DEPTH),
    localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              inst_valid_i,
    output logic              inst_ready_o,
    input  logic              flush_i,
    input  logic              dec_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o,
    output logic [CNT_W-1:0]  count_o
);

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full, empty, push, pop;

    // Status flags come only from the registered count. This keeps
    // dec_ready_i and flush_i from having a combinational path to ready.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A flush suppresses both the push and the pop for the same cycle.
    assign push = inst_valid_i & ~full  & ~flush_i;
    assign pop  = ~empty & dec_ready_i & ~flush_i;

    assign inst_ready_o = ~full;
    assign inst_valid_o = ~empty;
    assign count_o      = count_q;

    // Head presentation: force NOP/0 when empty so decode never sees stale data.
    always_comb begin
        inst_o      = NOP_INST;
        inst_addr_o = '0;
        if (!empty) begin
            inst_o      = mem_q[rd_ptr_q].inst;
            inst_addr_o = mem_q[rd_ptr_q].addr;
        end
    end

    // Next-state pointers and occupancy. Flush wins over everything else.
    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage. It has no reset because the count and the empty mux
    // hide stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q].inst <= inst_i;
            mem_q[wr_ptr_q].addr <= inst_addr_i;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// Bench for ifu_fetch_buffer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue model.
module tb_ifu_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h00000013;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       inst_i = '0;
    logic [31:0]       inst_addr_i = '0;
    logic              inst_valid_i = 1'b0;
    logic              inst_ready_o;
    logic              flush_i = 1'b0;
    logic              dec_ready_i = 1'b0;
    logic [31:0]       inst_o;
    logic [31:0]       inst_addr_o;
    logic              inst_valid_o;
    logic [CNT_W-1:0]  count_o;

    int checks = 0;
    int errors = 0;

    ifu_fetch_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .inst_valid_i(inst_valid_i),
        .inst_ready_o(inst_ready_o), .flush_i(flush_i), .dec_ready_i(dec_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: a plain FIFO queue of {inst, addr}
    typedef struct { logic [31:0] inst; logic [31:0] addr; } ent_t;
    ent_t q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
        end else if (flush_i) begin
            q.delete();
        end else begin
            bit do_pop, do_push;
            do_pop  = (q.size() != 0) && dec_ready_i;
            do_push = inst_valid_i && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{inst_i, inst_addr_i});
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [31:0] ei, ea;
        int n;
        n  = q.size();
        ei = (n != 0) ? q[0].inst : NOP;
        ea = (n != 0) ? q[0].addr : 32'h0;
        checks++;
        if (inst_valid_o !== (n != 0) || inst_ready_o !== (n != DEPTH) ||
            int'(count_o) != n || inst_o !== ei || inst_addr_o !== ea) begin
            errors++;
            $display("FAIL model @%0t: got v=%b r=%b cnt=%0d inst=%h addr=%h exp v=%b r=%b cnt=%0d inst=%h addr=%h",
                     $time, inst_valid_o, inst_ready_o, count_o, inst_o, inst_addr_o,
                     n != 0, n != DEPTH, n, ei, ea);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input logic [31:0] i, input logic [31:0] a,
                       input bit dr, input bit fl);
        inst_valid_i = v; inst_i = i; inst_addr_i = a;
        dec_ready_i = dr; flush_i = fl;
    endtask

    task automatic chk_empty(input string name);
        chk({name, ".valid"}, {31'b0, inst_valid_o}, 32'd0);
        chk({name, ".inst"},  inst_o, NOP);
        chk({name, ".addr"},  inst_addr_o, 32'h0);
        chk({name, ".count"}, {{(32-CNT_W){1'b0}}, count_o}, 32'd0);
        chk({name, ".ready"}, {31'b0, inst_ready_o}, 32'd1);
    endtask

    initial begin
        logic [31:0] exp_inst [4];
        exp_inst[0] = 32'h11; exp_inst[1] = 32'h22; exp_inst[2] = 32'h33; exp_inst[3] = 32'h44;

        // Reset state
        #2;
        chk_empty("reset");
        tick(); tick();
        rst = 1'b1;
        tick();

        // Fill to full, ignore the 5th push, drain in order
        for (int k = 0; k < 4; k++) begin
            drv(1, exp_inst[k], 32'h1000 + 32'(4*k), 0, 0);
            tick();
        end
        chk("fill.count", {{(32-CNT_W){1'b0}}, count_o}, 32'd4);
        chk("fill.ready", {31'b0, inst_ready_o}, 32'd0);
        drv(1, 32'h55, 32'h1010, 0, 0);
        tick();
        chk("fill.5th_ignored", {{(32-CNT_W){1'b0}}, count_o}, 32'd4);
        drv(0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            chk("drain.inst", inst_o, exp_inst[k]);
            chk("drain.addr", inst_addr_o, 32'h1000 + 32'(4*k));
            tick();
        end
        chk_empty("drained");

        // Wrap: steady push+pop, count stays at 1
        drv(1, 32'hA000, 32'h2000, 0, 0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            drv(1, 32'hA000 + 32'(k), 32'h2000 + 32'(4*k), 1, 0);
            chk("wrap.head_addr", inst_addr_o, 32'h2000 + 32'(4*(k-1)));
            chk("wrap.count", {{(32-CNT_W){1'b0}}, count_o}, 32'd1);
            tick();
        end
        drv(0, 0, 0, 1, 0);
        chk("wrap.last_addr", inst_addr_o, 32'h2028);
        tick();

        // Full with simultaneous push request: only the pop happens
        for (int k = 0; k < 4; k++) begin
            drv(1, 32'hB0 + 32'(k), 32'h4000 + 32'(4*k), 0, 0);
            tick();
        end
        drv(1, 32'hBF, 32'h4010, 1, 0);
        tick();
        chk("fullpop.count", {{(32-CNT_W){1'b0}}, count_o}, 32'd3);
        chk("fullpop.ready", {31'b0, inst_ready_o}, 32'd1);
        chk("fullpop.head", inst_addr_o, 32'h4004);
        drv(1, 32'hC0, 32'h4014, 0, 0);
        tick();
        chk("fullpop.next_push", {{(32-CNT_W){1'b0}}, count_o}, 32'd4);

        // Flush: count=3, flush with push+pop, buffer becomes empty
        drv(0, 0, 0, 0, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drv(1, 32'hD0 + 32'(k), 32'h5000 + 32'(4*k), 0, 0);
            tick();
        end
        chk("flush.pre_count", {{(32-CNT_W){1'b0}}, count_o}, 32'd3);
        drv(1, 32'hDD, 32'h500C, 1, 1);
        tick();
        chk_empty("flush");
        drv(1, 32'hEE, 32'h6000, 0, 1);
        tick();
        chk_empty("flush_held");
        drv(1, 32'h99, 32'h3000, 0, 0);
        tick();
        chk("flush.next_inst", inst_o, 32'h99);
        chk("flush.next_addr", inst_addr_o, 32'h3000);
        chk("flush.next_count", {{(32-CNT_W){1'b0}}, count_o}, 32'd1);

        // Empty pop: no underflow, pointers do not move
        drv(0, 0, 0, 1, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_empty("emptypop");
        end
        drv(1, 32'h77, 32'h7000, 0, 0);
        tick();
        drv(1, 32'h78, 32'h7004, 0, 0);
        tick();
        drv(0, 0, 0, 1, 0);
        chk("emptypop.head", inst_addr_o, 32'h7000);
        tick();
        chk("emptypop.second", inst_addr_o, 32'h7004);
        tick();

        // Reset asserted mid-stream with count=3 acts at once
        for (int k = 0; k < 3; k++) begin
            drv(1, 32'hF0 + 32'(k), 32'h8000 + 32'(4*k), 0, 0);
            tick();
        end
        chk("midrst.pre_count", {{(32-CNT_W){1'b0}}, count_o}, 32'd3);
        #2 rst = 1'b0;
        #1;
        chk_empty("midrst");
        drv(0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();

        // Randomized traffic, checked by the per-cycle model compare
        begin
            logic [31:0] a;
            a = 32'h9000;
            for (int c = 0; c < 3000; c++) begin
                drv($urandom_range(0, 9) < 7, $urandom, a,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
                tick();
                a = a + 32'd4;
            end
        end
        drv(0, 0, 0, 0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
